gf_divider: RTL and testbench

Sequential GF(2^M) divider: computes q = a · b⁻¹ mod f(x) with the binary extended Euclidean algorithm, one reduction step per clock. It is the inverse operation to the GF adder/multiplier datapath in `top`. Division replaces multiplication by an inverse, so a result from the multiplier can be divided back to recover its operand. Operands are captured on a start pulse, and the result is reported with a one-cycle done pulse.

---
 rtl/gf_divider.sv | 124 ++++++++++++
 tb/tb_gf_divider.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gf_divider.sv
// Sequential GF(2^M) divider, q = a * b^-1 mod POLY, via the binary extended Euclidean algorithm.
// Optional `GF_DIVIDER_CYCLES_EN adds a RUN-cycle counter output `cycles`.
//
// state | meaning
// IDLE  | waiting for start; q/div_zero hold last result
// RUN   | one reduction step per clock
// DONE  | done pulse cycle; start here is accepted directly
module gf_divider #(
  parameter int         M    = 8,
  parameter logic [M:0] POLY = 9'h11B
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [M-1:0] q,
`ifdef GF_DIVIDER_CYCLES_EN
  output logic [7:0]   cycles,
`endif
  output logic         div_zero
);

  localparam int         DW  = $clog2(M + 1);
  localparam logic [M:0] ONE = {{M{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [M:0]  u, v, g1, g2;
  logic [DW-1:0] deg_u, deg_v;

  // Divide by x modulo POLY; adding POLY first makes the polynomial even.
  function automatic logic [M:0] half_mod(input logic [M:0] g);
    half_mod = (g[0] ? (g ^ POLY) : g) >> 1;
  endfunction

  always_comb begin
    deg_u = '0;
    deg_v = '0;
    for (int i = 0; i <= M; i++) begin
      if (u[i]) deg_u = DW'(i);
      if (v[i]) deg_v = DW'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      q        <= '0;
      div_zero <= 1'b0;
      u        <= '0;
      v        <= '0;
      g1       <= '0;
      g2       <= '0;
`ifdef GF_DIVIDER_CYCLES_EN
      cycles   <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= RUN;
            busy     <= 1'b1;
            u        <= {1'b0, b};
            v        <= POLY;
            g1       <= {1'b0, a};
            g2       <= '0;
            div_zero <= 1'b0;
`ifdef GF_DIVIDER_CYCLES_EN
            cycles   <= '0;
`endif
          end else if (state == DONE) begin
            state <= IDLE;
          end
        end
        RUN: begin
`ifdef GF_DIVIDER_CYCLES_EN
          cycles <= cycles + 8'd1;
`endif
          if (u == '0 || u == ONE || v == ONE) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            if (u == '0) begin
              q        <= '0;
              div_zero <= 1'b1;
            end else if (u == ONE) begin
              q <= g1[M-1:0];
            end else begin
              q <= g2[M-1:0];
            end
          end else if (!u[0]) begin
            u  <= u >> 1;
            g1 <= half_mod(g1);
          end else if (!v[0]) begin
            v  <= v >> 1;
            g2 <= half_mod(g2);
          end else if (deg_u > deg_v) begin
            u  <= u ^ v;
            g1 <= g1 ^ g2;
          end else begin
            v  <= v ^ u;
            g2 <= g2 ^ g1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gf_divider.sv
// Directed and randomised bench for gf_divider (M=8, POLY=0x11B).
module tb_gf_divider;
  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] q;
  logic       div_zero;
`ifdef GF_DIVIDER_CYCLES_EN
  logic [7:0] cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  gf_divider #(.M(8), .POLY(9'h11B)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .q        (q),
`ifdef GF_DIVIDER_CYCLES_EN
    .cycles   (cycles),
`endif
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] xx;
    p  = 8'h00;
    xx = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ xx;
      xx = {xx[6:0], 1'b0} ^ (xx[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  task automatic launch(input logic [7:0] aa, input logic [7:0] bb);
    a     = aa;
    b     = bb;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output int lat, output bit got);
    int i;
    i   = 0;
    got = 1'b0;
    lat = 0;
    while (!got && i < max_cyc) begin
      i++;
      @(posedge clk); #1;
      if (done === 1'b1) begin
        got = 1'b1;
        lat = i;
      end
    end
  endtask

  task automatic test_reset();
    int pulses;
    rst_n = 1'b0;
    start = 1'b1;
    a     = 8'h01;
    b     = 8'h53;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || q !== 8'h00 || div_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b done=%b q=%h div_zero=%b, required all 0", busy, done, q, div_zero);
    end
    start = 1'b0;
    rst_n = 1'b1;
    pulses = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL reset_no_done: saw %0d done pulses, required 0", pulses);
    end
  endtask

  task automatic test_directed();
    logic [7:0] va[6]   = '{8'h01, 8'h53, 8'hC1, 8'h9D, 8'h00, 8'h12};
    logic [7:0] vb[6]   = '{8'h53, 8'h53, 8'h83, 8'h01, 8'h07, 8'h00};
    logic [7:0] vq[6]   = '{8'hCA, 8'h01, 8'h57, 8'h9D, 8'h00, 8'h00};
    logic       vdz[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int         vlat[6] = '{0, 0, 0, 1, 0, 1};
    int lat;
    bit got;
    for (int k = 0; k < 6; k++) begin
      launch(va[k], vb[k]);
      n_checks++;
      if (busy !== 1'b1) begin
        n_fail++;
        $display("FAIL busy_after_start[%0d]: busy=%b, required 1", k, busy);
      end
      wait_done(34, lat, got);
      n_checks++;
      if (!got) begin
        n_fail++;
        $display("FAIL done_timeout[%0d]: no done within 34 cycles", k);
      end
      n_checks++;
      if (q !== vq[k] || div_zero !== vdz[k] || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL result[%0d]: q=%h div_zero=%b busy=%b, required q=%h div_zero=%b busy=0",
                 k, q, div_zero, busy, vq[k], vdz[k]);
      end
      if (vlat[k] != 0) begin
        n_checks++;
        if (lat !== vlat[k]) begin
          n_fail++;
          $display("FAIL latency[%0d]: done after edge %0d, required edge %0d", k, lat, vlat[k]);
        end
      end
      @(posedge clk); #1;
      n_checks++;
      if (done !== 1'b0 || q !== vq[k] || div_zero !== vdz[k]) begin
        n_fail++;
        $display("FAIL done_single_pulse[%0d]: done=%b q=%h div_zero=%b, required done=0 q=%h div_zero=%b",
                 k, done, q, div_zero, vq[k], vdz[k]);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int lat;
    bit got;
    launch(8'h01, 8'h53);
    @(posedge clk); #1;
    a     = 8'h02;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    b     = 8'h01;
    wait_done(34, lat, got);
    n_checks++;
    if (!got || q !== 8'hCA) begin
      n_fail++;
      $display("FAIL start_while_busy: got=%0b q=%h, required done and q=ca", got, q);
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || q !== 8'hCA) begin
      n_fail++;
      $display("FAIL start_while_busy_idle: busy=%b q=%h, required busy=0 q=ca", busy, q);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    bit got;
    launch(8'h9D, 8'h01);
    wait_done(34, lat, got);
    n_checks++;
    if (!got || q !== 8'h9D) begin
      n_fail++;
      $display("FAIL b2b_first: got=%0b q=%h, required done and q=9d", got, q);
    end
    launch(8'h01, 8'h53);
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0 || q !== 8'h9D) begin
      n_fail++;
      $display("FAIL b2b_accept: busy=%b done=%b q=%h, required busy=1 done=0 q=9d", busy, done, q);
    end
    wait_done(34, lat, got);
    n_checks++;
    if (!got || q !== 8'hCA) begin
      n_fail++;
      $display("FAIL b2b_second: got=%0b q=%h, required done and q=ca", got, q);
    end
  endtask

  task automatic test_mid_reset();
    int pulses;
    int lat;
    bit got;
    launch(8'h01, 8'h53);
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_busy: busy=%b, required 1", busy);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || q !== 8'h00 || div_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: busy=%b done=%b q=%h div_zero=%b, required all 0", busy, done, q, div_zero);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    pulses = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL mid_reset_no_done: saw %0d done pulses, required 0", pulses);
    end
    launch(8'h01, 8'h53);
    wait_done(34, lat, got);
    n_checks++;
    if (!got || q !== 8'hCA) begin
      n_fail++;
      $display("FAIL mid_reset_restart: got=%0b q=%h, required done and q=ca", got, q);
    end
  endtask

  task automatic test_random();
    logic [7:0] ra;
    logic [7:0] rb;
    int lat;
    bit got;
    for (int k = 0; k < 1000; k++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(1, 255));
      launch(ra, rb);
      wait_done(34, lat, got);
      n_checks++;
      if (!got || div_zero !== 1'b0 || gf_mul(q, rb) !== ra) begin
        n_fail++;
        $display("FAIL random[%0d]: a=%h b=%h got=%0b q=%h div_zero=%b q*b=%h, required q*b=%h div_zero=0",
                 k, ra, rb, got, q, div_zero, gf_mul(q, rb), ra);
      end
`ifdef GF_DIVIDER_CYCLES_EN
      n_checks++;
      if (cycles > 8'd33 || cycles == 8'd0) begin
        n_fail++;
        $display("FAIL random_cycles[%0d]: cycles=%0d, required 1..33", k, cycles);
      end
`endif
    end
  endtask

  initial begin
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    test_reset();
    test_directed();
    test_start_while_busy();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
